fp_result_collector: RTL and testbench

FP_RESULT_COLLECTOR -- requirements
Module: fp_result_collector

---
 rtl/fp_result_collector.sv | 90 +++++++++
 tb/tb_fp_result_collector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fp_result_collector.sv
// Output stage behind the FP multiplier: buffers products in a small FIFO and
// keeps sticky status flags plus operation/exception counters.
module fp_result_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_z,
    input  logic [7:0]                in_status,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_z,
    output logic [7:0]                out_status,
    output logic [7:0]                flags,
    input  logic                      flags_clr,
    output logic [CNT_W-1:0]          op_count,
    output logic [CNT_W-1:0]          exc_count,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  status;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [7:0]    new_bits;

    // in_ready depends only on level, so a full FIFO refuses even while popping.
    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign new_bits  = {2'b00, in_status[5:0]};

    assign head       = mem[rd_ptr];
    assign out_z      = out_valid ? head.z      : 32'h0;
    assign out_status = out_valid ? head.status : 8'h00;

    // Storage is left unreset; stale entries are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_z, in_status};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A clear drops old state only; the bits of a coincident push still land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 8'h00;
        end else if (flags_clr) begin
            flags <= push ? new_bits : 8'h00;
        end else if (push) begin
            flags <= flags | new_bits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count  <= '0;
            exc_count <= '0;
        end else if (push) begin
            op_count <= op_count + 1'b1;
            if (|in_status[4:1]) exc_count <= exc_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fp_result_collector.sv
// Randomized and directed bench for fp_result_collector against a queue-based
// reference model of the FIFO, sticky flags and counters.
module tb_fp_result_collector;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   flags_clr = 1'b0;
    logic [31:0]            in_z = 32'h0;
    logic [7:0]             in_status = 8'h00;
    logic                   in_ready, out_valid;
    logic [31:0]            out_z;
    logic [7:0]             out_status, flags;
    logic [CNT_W-1:0]       op_count, exc_count;
    logic [$clog2(DEPTH):0] level;

    fp_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_status(in_status),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_status(out_status),
        .flags(flags), .flags_clr(flags_clr),
        .op_count(op_count), .exc_count(exc_count), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        logic [7:0]  s;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  m_flags;
    int unsigned m_op, m_exc;
    int          n_assert = 0;
    int          n_fail = 0;
    localparam logic [31:0] CMASK = (32'd1 << CNT_W) - 32'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_flags = 8'h00;
        m_op    = 0;
        m_exc   = 0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ez;
        logic [7:0]  es;
        ez = 32'h0;
        es = 8'h00;
        if (q.size() != 0) begin
            ez = q[0].z;
            es = q[0].s;
        end
        check({tag, ".in_ready"},   32'(in_ready),   32'(q.size() != DEPTH));
        check({tag, ".out_valid"},  32'(out_valid),  32'(q.size() != 0));
        check({tag, ".out_z"},      out_z,           ez);
        check({tag, ".out_status"}, 32'(out_status), 32'(es));
        check({tag, ".level"},      32'(level),      q.size());
        check({tag, ".flags"},      32'(flags),      32'(m_flags));
        check({tag, ".op_count"},   32'(op_count),   m_op & CMASK);
        check({tag, ".exc_count"},  32'(exc_count),  m_exc & CMASK);
    endtask

    // One clock: model decides push/pop from pre-edge state, then outputs are checked.
    task automatic cycle(input string tag);
        bit push, pop;
        push = in_valid && (q.size() != DEPTH);
        pop  = out_ready && (q.size() != 0);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (flags_clr)  m_flags = push ? {2'b00, in_status[5:0]} : 8'h00;
        else if (push)  m_flags = m_flags | {2'b00, in_status[5:0]};
        if (push) begin
            q.push_back('{z: in_z, s: in_status});
            m_op++;
            if (in_status[1] || in_status[2] || in_status[3] || in_status[4]) m_exc++;
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] z, input logic [7:0] s,
                         input logic ordy, input logic clr);
        in_valid  = v;
        in_z      = z;
        in_status = s;
        out_ready = ordy;
        flags_clr = clr;
    endtask

    initial begin
        model_reset();
        #3 check_all("reset");
        #4 rst_n = 1'b1;

        // single transfer, first push right after reset release
        drive(1, 32'h3FC00000, 8'h00, 0, 0);
        cycle("single");
        check("single.z_const", out_z, 32'h3FC00000);
        check("single.op_const", 32'(op_count), 32'd1);
        drive(0, 32'h0, 8'h00, 1, 0);
        cycle("single.pop");

        // fill and stall, then drain
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h40000000 + 32'(i), 8'h00, 0, 0);
            cycle("fill");
        end
        check("fill.in_ready_const", 32'(in_ready), 32'd0);
        check("fill.op_const", 32'(op_count), 32'd5);
        drive(0, 32'h0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) begin
            check("drain.order", out_z, 32'h40000000 + 32'(i));
            cycle("drain");
        end
        cycle("drain.idle");
        check("drain.z_zero", out_z, 32'h0);

        // sticky flags
        drive(1, 32'h3F800000, 8'h20, 1, 0);
        cycle("flags.a");
        drive(1, 32'h3F800001, 8'h12, 1, 0);
        cycle("flags.b");
        check("flags.const", 32'(flags), 32'h32);
        check("flags.exc_const", 32'(exc_count), 32'd1);
        drive(0, 32'h0, 8'h00, 1, 1);
        cycle("flags.clr");
        check("flags.clr_const", 32'(flags), 32'h00);
        check("flags.clr_op_const", 32'(op_count), 32'd7);

        // clear/push collision
        drive(1, 32'h12345678, 8'h3F, 1, 0);
        cycle("coll.set");
        drive(1, 32'h87654321, 8'hC4, 1, 1);
        cycle("coll.hit");
        check("coll.flags_const", 32'(flags), 32'h04);
        check("coll.exc_const", 32'(exc_count), 32'd3);
        drive(0, 32'h0, 8'h00, 1, 0);
        cycle("coll.drain");

        // streaming: level holds at 1, pointers wrap
        for (int i = 0; i < 20; i++) begin
            drive(1, $urandom, 8'($urandom), 1, 0);
            cycle("stream");
            check("stream.level_const", 32'(level), 32'd1);
        end

        // random traffic with stalls and changing stalled inputs
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 8'($urandom),
                  1'($urandom_range(0, 2) == 0 ? (i % 64 < 32) : 1),
                  1'($urandom_range(0, 15) == 0));
            cycle("rand");
        end

        // reset mid-flight: reach level=3, op_count=7 first
        drive(0, 32'h0, 8'h00, 0, 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("rst1");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'hA0000000 + 32'(i), 8'h02, 1, 0);
            cycle("pre.stream");
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'hB0000000 + 32'(i), 8'h01, 0, 0);
            cycle("pre.fill");
        end
        check("pre.level_const", 32'(level), 32'd3);
        check("pre.op_const", 32'(op_count), 32'd7);
        drive(0, 32'h0, 8'h00, 1, 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("midrst");
        check("midrst.in_ready_const", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        drive(1, 32'hC0490FDB, 8'h08, 0, 0);
        cycle("post");
        check("post.z_const", out_z, 32'hC0490FDB);
        drive(0, 32'h0, 8'h00, 1, 0);
        cycle("post.pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
